// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard/stall/flush sequencer with event counters
module pipe_hazard_ctrl #(
  parameter int FORWARDING = 0,
  parameter int CNT_W      = 16,
  parameter int MAX_WAIT   = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [15:0] MAX_WAIT_L = 16'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [15:0]       timer_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, wait_cnt_q;
  logic              err_q;

  // Register 0 is hardwired, so it can never carry a dependency.
  logic rs_ex, rt_ex, rs_mem, rt_mem, hit_ex, hit_mem, haz;

  assign rs_ex   = (id_rs_i != 5'd0) && (id_rs_i == ex_rd_i);
  assign rt_ex   = id_use_rt_i && (id_rt_i != 5'd0) && (id_rt_i == ex_rd_i);
  assign rs_mem  = (id_rs_i != 5'd0) && (id_rs_i == mem_rd_i);
  assign rt_mem  = id_use_rt_i && (id_rt_i != 5'd0) && (id_rt_i == mem_rd_i);
  assign hit_ex  = rs_ex | rt_ex;
  assign hit_mem = rs_mem | rt_mem;
  assign haz     = (FORWARDING != 0) ? (ex_memread_i & hit_ex)
                                     : ((ex_regwrite_i & hit_ex) | (mem_regwrite_i & hit_mem));

  always_comb begin
    state_d        = RUN;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    ex_mem_write_o = 1'b1;
    mem_wb_write_o = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (!rst_i) begin
      if (mem_busy_i) begin
        // Frozen pipe keeps branch_taken_i stable until memory releases it.
        state_d        = WAIT;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_write_o  = 1'b0;
        ex_mem_write_o = 1'b0;
        mem_wb_write_o = 1'b0;
      end else if (branch_taken_i) begin
        state_d        = FLUSH;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (haz) begin
        state_d        = STALL;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_flush_o  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == STALL && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_d == FLUSH && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (state_d == WAIT  && wait_cnt_q  != '1) wait_cnt_q  <= wait_cnt_q  + CNT_W'(1);
      if (mem_busy_i) begin
        if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;
        // timer_q already holds MAX_WAIT busy cycles, so this one exceeds the limit.
        if (timer_q >= MAX_WAIT_L) err_q <= 1'b1;
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign wait_cnt_o    = wait_cnt_q;
  assign err_timeout_o = err_q;

endmodule
